// File: rtl/counter_mod_7_b.sv
// Modulo-N 7-bit up/down counter for one clock field. It has a combinational
// terminal-count output, a registered carry/borrow pulse and registered BCD digits.
module counter_mod_7_b #(
  parameter logic [6:0] RST_VAL = 7'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic [6:0] max_val,
  output logic [6:0] cnt,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       tc,
  output logic       co
);

  logic [6:0] cnt_q, cnt_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       co_q, co_d;
  logic [6:0] load_clamped;

  // Shift-and-add-3 conversion. It is used only where the digits cannot be
  // derived incrementally: reset, load, and a jump to max_val.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [14:0] s;
    s = {8'd0, v};
    for (int unsigned i = 0; i < 7; i++) begin
      if (s[10:7] >= 4'd5)  s[10:7]  = s[10:7]  + 4'd3;
      if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
      s = s << 1;
    end
    return s[14:7];
  endfunction

  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    cnt_d  = cnt_q;
    tens_d = tens_q;
    ones_d = ones_q;
    co_d   = 1'b0;
    if (load) begin
      cnt_d            = load_clamped;
      {tens_d, ones_d} = bin2bcd(load_clamped);
    end else if (en) begin
      if (up) begin
        if (cnt_q >= max_val) begin
          cnt_d  = '0;
          tens_d = '0;
          ones_d = '0;
          co_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 7'd1;
          if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
      end else begin
        if (cnt_q == 7'd0 || cnt_q > max_val) begin
          // Borrow from zero and recovery from an out-of-range count both land on max_val.
          cnt_d            = max_val;
          {tens_d, ones_d} = bin2bcd(max_val);
          co_d             = (cnt_q == 7'd0);
        end else begin
          cnt_d = cnt_q - 7'd1;
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q            <= RST_VAL;
      {tens_q, ones_q} <= bin2bcd(RST_VAL);
      co_q             <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      co_q   <= co_d;
    end
  end

  assign tc       = en & (up ? (cnt_q >= max_val) : (cnt_q == 7'd0));
  assign cnt      = cnt_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign co       = co_q;

endmodule
